// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared shift-add multiplier.
// Grants one operation at a time, waits for the multiplier, returns the product.
`timescale 1ns/1ps
module mult_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [WIDTH-1:0]     req0_mplier,
  input  logic [WIDTH-1:0]     req0_mcand,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [WIDTH-1:0]     req1_mplier,
  input  logic [WIDTH-1:0]     req1_mcand,
  output logic                 req1_ready,
  output logic                 resp0_valid,
  output logic [2*WIDTH-1:0]   resp0_product,
  output logic                 resp0_error,
  output logic                 resp1_valid,
  output logic [2*WIDTH-1:0]   resp1_product,
  output logic                 resp1_error,
  output logic                 mult_load,
  output logic [WIDTH-1:0]     mult_mplier,
  output logic [WIDTH-1:0]     mult_mcand,
  input  logic [2*WIDTH-1:0]   mult_product,
  input  logic                 mult_done,
  output logic                 busy,
  output logic                 owner
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             owner_next;
  logic [WIDTH-1:0] mplier_next;
  logic [WIDTH-1:0] mcand_next;
  logic [PW-1:0]    result;
  logic [PW-1:0]    result_next;
  logic             error;
  logic             error_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             grant0_c;
  logic             grant1_c;

  // Next-state, arbitration and datapath capture.
  always_comb begin
    state_next  = state;
    owner_next  = owner;
    mplier_next = mult_mplier;
    mcand_next  = mult_mcand;
    result_next = result;
    error_next  = error;
    count_next  = count;
    grant0_c    = 1'b0;
    grant1_c    = 1'b0;

    case (state)
      S_IDLE: begin
        // owner holds the last grant; on a tie the other requester wins.
        if (req0_valid && (!req1_valid || owner)) begin
          grant0_c = 1'b1;
        end else if (req1_valid) begin
          grant1_c = 1'b1;
        end
        if (grant0_c) begin
          owner_next  = 1'b0;
          mplier_next = req0_mplier;
          mcand_next  = req0_mcand;
          state_next  = S_LOAD;
        end else if (grant1_c) begin
          owner_next  = 1'b1;
          mplier_next = req1_mplier;
          mcand_next  = req1_mcand;
          state_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        count_next = CW'(0);
        state_next = S_WAIT;
      end
      S_WAIT: begin
        count_next = count + CW'(1);
        // done seen on the first WAIT cycle belongs to the previous operation
        if (mult_done && (count != CW'(0))) begin
          result_next = mult_product;
          error_next  = 1'b0;
          state_next  = S_RESP;
        end else if (count_next == CW'(TIMEOUT)) begin
          result_next = PW'(0);
          error_next  = 1'b1;
          state_next  = S_RESP;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Accept is same-cycle so operands are captured on the edge that ends the pulse.
  assign req0_ready    = grant0_c;
  assign req1_ready    = grant1_c;
  assign resp0_product = result;
  assign resp1_product = result;

  // State register and registered outputs decoded from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      owner       <= 1'b1;
      mult_mplier <= '0;
      mult_mcand  <= '0;
      result      <= '0;
      error       <= 1'b0;
      count       <= '0;
      mult_load   <= 1'b0;
      busy        <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_error <= 1'b0;
      resp1_error <= 1'b0;
    end else begin
      state       <= state_next;
      owner       <= owner_next;
      mult_mplier <= mplier_next;
      mult_mcand  <= mcand_next;
      result      <= result_next;
      error       <= error_next;
      count       <= count_next;
      mult_load   <= (state_next == S_LOAD);
      busy        <= (state_next != S_IDLE);
      resp0_valid <= (state_next == S_RESP) && !owner_next;
      resp1_valid <= (state_next == S_RESP) && owner_next;
      resp0_error <= (state_next == S_RESP) && !owner_next && error_next;
      resp1_error <= (state_next == S_RESP) && owner_next && error_next;
    end
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: table of operations plus hand-written
// reset, alternation and withdrawal sequences, checked through a scoreboard.
`timescale 1ns/1ps
module tb_mult_arbiter;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 40;

  typedef struct {
    logic        idx;
    logic [7:0]  a;
    logic [7:0]  b;
    int          hold;
    logic [15:0] prod;
    logic        err;
    int          lat;
  } item_t;

  typedef struct {
    logic [1:0]  who;
    logic        first;
    logic [7:0]  a0;
    logic [7:0]  b0;
    logic [15:0] p0;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic [15:0] p1;
    int          dly;
    logic        err;
    int          lat;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0_valid = 1'b0;
  logic [7:0]  req0_mplier = 8'h00;
  logic [7:0]  req0_mcand = 8'h00;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [7:0]  req1_mplier = 8'h00;
  logic [7:0]  req1_mcand = 8'h00;
  logic        req1_ready;
  logic        resp0_valid;
  logic [15:0] resp0_product;
  logic        resp0_error;
  logic        resp1_valid;
  logic [15:0] resp1_product;
  logic        resp1_error;
  logic        mult_load;
  logic [7:0]  mult_mplier;
  logic [7:0]  mult_mcand;
  logic [15:0] mult_product;
  logic        mult_done;
  logic        busy;
  logic        owner;

  mult_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_mplier(req0_mplier), .req0_mcand(req0_mcand), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_mplier(req1_mplier), .req1_mcand(req1_mcand), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_product(resp0_product), .resp0_error(resp0_error),
    .resp1_valid(resp1_valid), .resp1_product(resp1_product), .resp1_error(resp1_error),
    .mult_load(mult_load), .mult_mplier(mult_mplier), .mult_mcand(mult_mcand),
    .mult_product(mult_product), .mult_done(mult_done),
    .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    load_cyc = 0;
  int    grants0 = 0;
  int    mdelay = 2;
  int    hold0 = 0;
  int    hold1 = 0;
  logic  acc0 = 1'b0;
  logic  acc1 = 1'b0;
  logic  prev_load = 1'b0;
  item_t cur0;
  item_t cur1;
  item_t q0[$];
  item_t q1[$];
  item_t sb[$];
  logic  exp_grant[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic item_t mk_op(input logic [7:0] a, input logic [7:0] b, input int dly, input int hold);
    item_t o;
    o.idx  = 1'b0;
    o.a    = a;
    o.b    = b;
    o.hold = hold;
    o.err  = (dly == 0) || (dly > int'(TIMEOUT) - 2);
    o.prod = o.err ? 16'h0000 : 16'(a) * 16'(b);
    o.lat  = o.err ? int'(TIMEOUT) + 1 : dly + 3;
    return o;
  endfunction

  // Multiplier model: done stays high until the cycle after a new load starts.
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic       m_start;
  int         m_cd;
  always @(posedge clock) begin
    if (reset) begin
      mult_done    <= 1'b0;
      mult_product <= 16'h0000;
      m_start      <= 1'b0;
      m_cd         <= 0;
      m_a          <= 8'h00;
      m_b          <= 8'h00;
    end else begin
      m_start <= mult_load;
      if (mult_load) begin
        m_a <= mult_mplier;
        m_b <= mult_mcand;
      end
      if (m_start) begin
        mult_done <= 1'b0;
        m_cd      <= mdelay;
      end else if (m_cd == 1) begin
        mult_done    <= 1'b1;
        mult_product <= 16'(m_a) * 16'(m_b);
        m_cd         <= 0;
      end else if (m_cd > 1) begin
        m_cd <= m_cd - 1;
      end
    end
  end

  // Requester drivers: hold valid until accepted, or withdraw after hold cycles.
  always @(posedge clock) begin
    #1;
    if (acc0) req0_valid = 1'b0;
    else if (req0_valid && hold0 > 0) begin
      hold0--;
      if (hold0 == 0) req0_valid = 1'b0;
    end
    if (!req0_valid && q0.size() > 0) begin
      cur0 = q0.pop_front();
      req0_mplier = cur0.a;
      req0_mcand  = cur0.b;
      hold0       = cur0.hold;
      req0_valid  = 1'b1;
    end
    if (acc1) req1_valid = 1'b0;
    else if (req1_valid && hold1 > 0) begin
      hold1--;
      if (hold1 == 0) req1_valid = 1'b0;
    end
    if (!req1_valid && q1.size() > 0) begin
      cur1 = q1.pop_front();
      req1_mplier = cur1.a;
      req1_mcand  = cur1.b;
      hold1       = cur1.hold;
      req1_valid  = 1'b1;
    end
  end

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clock) begin
    item_t e;
    cyc++;
    if (reset) begin
      acc0 = 1'b0;
      acc1 = 1'b0;
      prev_load = 1'b0;
    end else begin
      acc0 = req0_ready;
      acc1 = req1_ready;
      if (req0_ready || req1_ready) begin
        chk("one_ready", 32'(req0_ready & req1_ready), 32'd0);
        if (exp_grant.size() == 0) fail_now("unexpected_grant");
        else chk("grant_idx", 32'(req1_ready), 32'(exp_grant.pop_front()));
        e = req1_ready ? cur1 : cur0;
        e.idx = req1_ready;
        sb.push_back(e);
        if (req0_ready) grants0++;
      end
      if (mult_load) begin
        chk("load_not_consecutive", 32'(prev_load), 32'd0);
        load_cyc = cyc;
        if (sb.size() == 0) fail_now("load_without_grant");
        else begin
          chk("mult_mplier", 32'(mult_mplier), 32'(sb[$].a));
          chk("mult_mcand", 32'(mult_mcand), 32'(sb[$].b));
        end
      end
      if (resp0_valid || resp1_valid) begin
        chk("one_resp", 32'(resp0_valid & resp1_valid), 32'd0);
        if (sb.size() == 0) fail_now("unexpected_resp");
        else begin
          e = sb.pop_front();
          chk("resp_idx", 32'(resp1_valid), 32'(e.idx));
          chk("resp_product", 32'(resp1_valid ? resp1_product : resp0_product), 32'(e.prod));
          chk("resp_error", 32'(resp1_valid ? resp1_error : resp0_error), 32'(e.err));
          chk("resp_latency", 32'(cyc - load_cyc), 32'(e.lat));
        end
      end
      prev_load = mult_load;
    end
  end

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0 || exp_grant.size() != 0 ||
            req0_valid || req1_valid || busy) && n < maxc) begin
      @(negedge clock);
      n++;
    end
    if (n >= maxc) fail_now("drain_timeout");
    @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  vec_t tv[9];

  initial begin
    int n;
    int g0;
    tv[0] = '{2'b01, 1'b0, 8'hAE, 8'h01, 16'h00AE, 8'h00, 8'h00, 16'h0000, 2, 1'b0, 5};
    tv[1] = '{2'b10, 1'b1, 8'h00, 8'h00, 16'h0000, 8'h12, 8'h34, 16'h03A8, 1, 1'b0, 4};
    tv[2] = '{2'b11, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 8'h80, 8'h02, 16'h0100, 3, 1'b0, 6};
    tv[3] = '{2'b11, 1'b0, 8'h05, 8'h07, 16'h0023, 8'h0A, 8'h0B, 16'h006E, 1, 1'b0, 4};
    tv[4] = '{2'b01, 1'b0, 8'h00, 8'h55, 16'h0000, 8'h00, 8'h00, 16'h0000, 5, 1'b0, 8};
    tv[5] = '{2'b11, 1'b1, 8'h11, 8'h11, 16'h0121, 8'hFF, 8'h01, 16'h00FF, 2, 1'b0, 5};
    tv[6] = '{2'b10, 1'b1, 8'h00, 8'h00, 16'h0000, 8'h5A, 8'hA5, 16'h0000, 0, 1'b1, 41};
    tv[7] = '{2'b01, 1'b0, 8'hC3, 8'h3C, 16'h2DB4, 8'h00, 8'h00, 16'h0000, 38, 1'b0, 41};
    tv[8] = '{2'b10, 1'b1, 8'h00, 8'h00, 16'h0000, 8'h7F, 8'h81, 16'h0000, 39, 1'b1, 41};

    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_owner", 32'(owner), 32'd1);
    chk("rst_mult_load", 32'(mult_load), 32'd0);
    chk("rst_resp_valid", 32'({resp1_valid, resp0_valid}), 32'd0);
    chk("rst_resp_error", 32'({resp1_error, resp0_error}), 32'd0);
    chk("rst_operands", 32'({mult_mplier, mult_mcand}), 32'd0);
    chk("rst_product", 32'(resp0_product), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);

    // Table-driven operations.
    for (int i = 0; i < 9; i++) begin
      item_t o;
      mdelay = tv[i].dly;
      if (tv[i].who == 2'b11) begin
        exp_grant.push_back(tv[i].first);
        exp_grant.push_back(!tv[i].first);
      end else begin
        exp_grant.push_back(tv[i].who[1]);
      end
      if (tv[i].who[0]) begin
        o = '{1'b0, tv[i].a0, tv[i].b0, 0, tv[i].p0, tv[i].err, tv[i].lat};
        q0.push_back(o);
      end
      if (tv[i].who[1]) begin
        o = '{1'b1, tv[i].a1, tv[i].b1, 0, tv[i].p1, tv[i].err, tv[i].lat};
        q1.push_back(o);
      end
      wait_drain(200);
    end

    // Simultaneous requests right after reset alternate starting with req0.
    pulse_reset();
    @(negedge clock);
    mdelay = 1;
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    exp_grant.push_back(1'b0);
    exp_grant.push_back(1'b1);
    q0.push_back(mk_op(8'h21, 8'h03, 1, 0));
    q0.push_back(mk_op(8'h40, 8'h40, 1, 0));
    q1.push_back(mk_op(8'h0F, 8'h0F, 1, 0));
    q1.push_back(mk_op(8'hE0, 8'h02, 1, 0));
    wait_drain(300);

    // Reset during WAIT aborts the operation without a response.
    mdelay = 0;
    exp_grant.push_back(1'b0);
    q0.push_back(mk_op(8'h33, 8'h44, 0, 0));
    n = 0;
    while (!mult_load && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) fail_now("abort_load_timeout");
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b1;
    sb.delete();
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_owner", 32'(owner), 32'd1);
    chk("abort_no_resp", 32'({resp1_valid, resp0_valid}), 32'd0);
    repeat (4) @(negedge clock);
    chk("abort_idle", 32'(busy), 32'd0);
    mdelay = 2;
    exp_grant.push_back(1'b1);
    q1.push_back(mk_op(8'h9C, 8'h03, 2, 0));
    wait_drain(200);

    // A request withdrawn before its ready pulse is never served.
    g0 = grants0;
    mdelay = 30;
    exp_grant.push_back(1'b1);
    q1.push_back(mk_op(8'h07, 8'h09, 30, 0));
    n = 0;
    while (sb.size() == 0 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) fail_now("withdraw_grant_timeout");
    q0.push_back(mk_op(8'h66, 8'h77, 30, 3));
    wait_drain(200);
    repeat (5) @(negedge clock);
    chk("withdrawn_not_served", 32'(grants0 - g0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: operand width; product width is 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 40: maximum WAIT cycles before abort.
REQ-003 clock  input  1  single clock; all logic updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N has an operation pending; held until reqN_ready.
REQ-006 reqN_mplier, reqN_mcand  input  WIDTH  (N=0,1) operands; stable while reqN_valid is high.
REQ-007 reqN_ready  output  1  (N=0,1) one-cycle accept pulse; operands captured this cycle.
REQ-008 respN_valid  output  1  (N=0,1) one-cycle result pulse to requester N.
REQ-009 respN_product  output  2*WIDTH  (N=0,1) result; valid only while respN_valid is high.
REQ-010 respN_error  output  1  (N=0,1) high with respN_valid when the operation timed out.
REQ-011 mult_load  output  1  load strobe to the shift-add multiplier.
REQ-012 mult_mplier, mult_mcand  output  WIDTH  operands to the multiplier; registered.
REQ-013 mult_product  input  2*WIDTH  multiplier result.
REQ-014 mult_done  input  1  multiplier completion flag.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 owner  output  1  index of the requester being served; last grant when idle.

Function
REQ-017 FSM states: IDLE, LOAD, WAIT, RESP.
REQ-018 IDLE: if any reqN_valid, grant one requester, pulse its reqN_ready, latch its operands into mult_mplier/mult_mcand, set owner, go to LOAD; otherwise stay in IDLE.
REQ-019 Arbitration is round-robin: when both are valid, grant the requester not granted last; when one is valid, grant it.
REQ-020 LOAD: drive mult_load high for exactly one cycle, clear the wait counter, go to WAIT.
REQ-021 WAIT: ignore mult_done in the first WAIT cycle (stale done from the previous operation); from the second cycle on, mult_done=1 latches mult_product into the result register and goes to RESP.
REQ-022 WAIT: the counter increments every cycle; if it reaches TIMEOUT without an accepted done, go to RESP with the error flag set and the result cleared to 0.
REQ-023 RESP: pulse respN_valid for owner only, with the latched product and error flag, then go to IDLE.
REQ-024 Latency: accept at cycle T, mult_load at T+1, done accepted at D >= T+3, respN_valid at D+1, next accept no earlier than D+2.
REQ-025 The FSM ignores reqN_valid outside IDLE; a pending request waits and no ready pulse is issued.
REQ-026 Product width is 2*WIDTH, passed through unmodified; no arithmetic is performed in this block.
REQ-027 At most one reqN_ready and one respN_valid is high in any cycle; mult_load is never high outside LOAD.
REQ-028 A requester that deasserts valid before its ready pulse is not served.

Reset
REQ-029 Reset forces IDLE; all ready, resp_valid, error, mult_load and busy outputs go to 0; operand, product and counter registers go to 0.
REQ-030 Reset sets the last grant to 1 and owner to 1, so requester 0 wins the first tie.
REQ-031 Reset asserted mid-operation aborts it: no resp pulse is issued for the aborted operation, and the FSM is in IDLE on the cycle after reset deasserts.

Verification
REQ-032 After reset, req0 = (0xAE, 0x01) only -> req0_ready pulses, mult_load pulses 1 cycle later; model done -> resp0_valid=1, resp0_product=0x00AE, resp0_error=0.
REQ-033 req0 and req1 asserted in the same cycle after reset -> req0 served first, then req1; reqs held for 4 operations -> grants alternate 0,1,0,1.
REQ-034 mult_done held high from the previous op -> it is not accepted in the first WAIT cycle; the result is taken only on a later done.
REQ-035 mult_done never asserts -> after 40 WAIT cycles, respN_valid=1, respN_error=1, respN_product=0, then IDLE.
REQ-036 reset pulsed during WAIT -> no respN_valid; busy=0 and owner=1 after reset; a new req1 is then accepted normally.
REQ-037 Every test checks that at most one of req0_ready/req1_ready is high in any cycle, and that mult_load is never high for two consecutive cycles.
